// File: rtl/pulse_event_arbiter.sv
// Multi-channel pulse qualifier feeding a round-robin valid/ready event port.
// Qualified events wait as pending flags; events that cannot be stored are counted.
module pulse_event_arbiter #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned DROP_W = 8,
  localparam int unsigned ID_W  = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic [N_CH-1:0]   noisy_in,
  output logic              ev_valid,
  output logic [ID_W-1:0]   ev_id,
  input  logic              ev_ready,
  output logic [N_CH-1:0]   pending,
  output logic [DROP_W-1:0] drop_cnt,
  input  logic              drop_clr
);

  localparam int unsigned CW1   = CNT_W + 1;
  localparam int unsigned IW1   = ID_W + 1;
  localparam int unsigned PC_W  = $clog2(N_CH + 1);
  localparam int unsigned SUM_W = DROP_W + PC_W;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_t;

  slot_t             slot_q, slot_d;
  logic [CNT_W-1:0]  cnt_q [N_CH];
  logic [CNT_W-1:0]  cnt_d [N_CH];
  logic [N_CH-1:0]   armed_q, armed_d;
  logic [N_CH-1:0]   fire, drop, pending_d, load_mask;
  logic [ID_W-1:0]   ev_id_d, rr_q, rr_d, sel;
  logic              found, load_opp, load;
  logic [CNT_W-1:0]  eff_len;
  logic [DROP_W-1:0] drop_d;
  logic [SUM_W-1:0]  drop_sum;
  logic [IW1-1:0]    idx;

  assign ev_valid = (slot_q == S_FULL);

  // Per-channel run counter; a run fires once when it reaches eff_len.
  always_comb begin
    eff_len = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i]   = cnt_q[i];
      armed_d[i] = armed_q[i];
      fire[i]    = 1'b0;
      if (!noisy_in[i]) begin
        cnt_d[i]   = '0;
        armed_d[i] = 1'b1;
      end else if (({1'b0, cnt_q[i]} + CW1'(1)) >= {1'b0, eff_len}) begin
        cnt_d[i]   = eff_len;
        fire[i]    = armed_q[i];
        armed_d[i] = 1'b0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Round-robin search starting just after the last loaded channel.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = {1'b0, rr_q} + IW1'(k);
      if (idx >= IW1'(N_CH)) begin
        idx = idx - IW1'(N_CH);
      end
      if (!found && pending[idx[ID_W-1:0]]) begin
        found = 1'b1;
        sel   = idx[ID_W-1:0];
      end
    end
    load_opp  = (slot_q == S_EMPTY) || ev_ready;
    load      = load_opp && found;
    load_mask = load ? (N_CH'(1) << sel) : '0;
  end

  // A fire on a channel being loaded in the same cycle re-pends instead of dropping.
  always_comb begin
    pending_d = (pending & ~load_mask) | fire;
    drop      = fire & pending & ~load_mask;
    drop_sum  = drop_clr ? '0 : SUM_W'(drop_cnt);
    for (int i = 0; i < N_CH; i++) begin
      drop_sum = drop_sum + SUM_W'(drop[i]);
    end
    drop_d = (drop_sum > SUM_W'({DROP_W{1'b1}})) ? '1 : DROP_W'(drop_sum);
  end

  // Output slot next state; stalled slot holds id and pointer.
  always_comb begin
    slot_d  = slot_q;
    ev_id_d = ev_id;
    rr_d    = rr_q;
    if (load_opp) begin
      if (found) begin
        slot_d  = S_FULL;
        ev_id_d = sel;
        rr_d    = sel;
      end else begin
        slot_d = S_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= S_EMPTY;
      ev_id    <= '0;
      rr_q     <= ID_W'(N_CH - 1);
      pending  <= '0;
      drop_cnt <= '0;
      armed_q  <= '1;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      slot_q   <= slot_d;
      ev_id    <= ev_id_d;
      rr_q     <= rr_d;
      pending  <= pending_d;
      drop_cnt <= drop_d;
      armed_q  <= armed_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Directed bench for pulse_event_arbiter: vector table plus hand-written
// sequences for drop saturation and mid-operation reset.
module tb_pulse_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cfg_len;
  logic [3:0] noisy_in;
  logic       ev_valid;
  logic [1:0] ev_id;
  logic       ev_ready;
  logic [3:0] pending;
  logic [7:0] drop_cnt;
  logic       drop_clr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst;
    logic [3:0] cfg;
    logic [3:0] noisy;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [1:0] id;
    logic [3:0] pend;
    logic [7:0] drop;
  } vec_t;

  vec_t vecs[$];

  pulse_event_arbiter #(.N_CH(4), .CNT_W(4), .DROP_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .noisy_in(noisy_in),
    .ev_valid(ev_valid), .ev_id(ev_id), .ev_ready(ev_ready),
    .pending(pending), .drop_cnt(drop_cnt), .drop_clr(drop_clr)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] c, input logic [3:0] n,
                     input logic rd, input logic cl, input logic v,
                     input logic [1:0] id, input logic [3:0] p, input logic [7:0] d);
    vec_t x;
    x.rst = r; x.cfg = c; x.noisy = n; x.rdy = rd; x.clr = cl;
    x.v = v; x.id = id; x.pend = p; x.drop = d;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] c, input logic [3:0] n,
                      input logic rd, input logic cl);
    rst = r; cfg_len = c; noisy_in = n; ev_ready = rd; drop_clr = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] id,
                           input logic [3:0] p, input logic [7:0] d);
    check({tag, " ev_valid"}, 32'(ev_valid), 32'(v));
    if (v) check({tag, " ev_id"}, 32'(ev_id), 32'(id));
    check({tag, " pending"}, 32'(pending), 32'(p));
    check({tag, " drop_cnt"}, 32'(drop_cnt), 32'(d));
  endtask

  initial begin
    rst = 1'b1; cfg_len = 4'd3; noisy_in = '0; ev_ready = 1'b1; drop_clr = 1'b0;

    // rst cfg noisy rdy clr | valid id pending drop
    add(1, 3, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
    // cfg_len=3: short burst ignored, long burst fires once
    add(0, 3, 4'b0001, 1, 0, 0, 0, 4'b0000, 0);
    add(0, 3, 4'b0001, 1, 0, 0, 0, 4'b0000, 0);
    add(0, 3, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
    add(0, 3, 4'b0001, 1, 0, 0, 0, 4'b0000, 0);
    add(0, 3, 4'b0001, 1, 0, 0, 0, 4'b0000, 0);
    add(0, 3, 4'b0001, 1, 0, 0, 0, 4'b0001, 0);
    add(0, 3, 4'b0001, 1, 0, 1, 0, 4'b0000, 0);
    add(0, 3, 4'b0001, 1, 0, 0, 0, 4'b0000, 0);
    add(0, 3, 4'b0001, 1, 0, 0, 0, 4'b0000, 0);
    add(0, 3, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
    // cfg_len=1: all four fire together, served 0,1,2,3, then ch3 alone
    add(1, 1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
    add(0, 1, 4'b1111, 1, 0, 0, 0, 4'b1111, 0);
    add(0, 1, 4'b0000, 1, 0, 1, 0, 4'b1110, 0);
    add(0, 1, 4'b0000, 1, 0, 1, 1, 4'b1100, 0);
    add(0, 1, 4'b0000, 1, 0, 1, 2, 4'b1000, 0);
    add(0, 1, 4'b0000, 1, 0, 1, 3, 4'b0000, 0);
    add(0, 1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
    add(0, 1, 4'b1000, 1, 0, 0, 0, 4'b1000, 0);
    add(0, 1, 4'b0000, 1, 0, 1, 3, 4'b0000, 0);
    add(0, 1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
    // cfg_len=0 acts as 1; same-cycle fire and load of ch3 keeps it pending
    add(0, 0, 4'b1000, 1, 0, 0, 0, 4'b1000, 0);
    add(0, 0, 4'b0000, 1, 0, 1, 3, 4'b0000, 0);
    add(0, 0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
    add(0, 0, 4'b0001, 0, 0, 0, 0, 4'b0001, 0);
    add(0, 0, 4'b1000, 0, 0, 1, 0, 4'b1000, 0);
    add(0, 0, 4'b0000, 0, 0, 1, 0, 4'b1000, 0);
    add(0, 0, 4'b1000, 1, 0, 1, 3, 4'b1000, 0);
    add(0, 0, 4'b0000, 1, 0, 1, 3, 4'b0000, 0);
    add(0, 0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
    // stalled ch1, ch2 fires twice: one drop, then ch2 served
    add(0, 1, 4'b0010, 0, 0, 0, 0, 4'b0010, 0);
    add(0, 1, 4'b0100, 0, 0, 1, 1, 4'b0100, 0);
    add(0, 1, 4'b0000, 0, 0, 1, 1, 4'b0100, 0);
    add(0, 1, 4'b0100, 0, 0, 1, 1, 4'b0100, 1);
    add(0, 1, 4'b0000, 1, 0, 1, 2, 4'b0000, 1);
    add(0, 1, 4'b0000, 1, 0, 0, 0, 4'b0000, 1);
    add(0, 1, 4'b0000, 1, 1, 0, 0, 4'b0000, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].cfg, vecs[i].noisy, vecs[i].rdy, vecs[i].clr);
      check_out($sformatf("row%0d", i), vecs[i].v, vecs[i].id, vecs[i].pend, vecs[i].drop);
    end

    // Drop saturation: ch1 stalled in the slot, ch0 pulses 301 times
    step(0, 1, 4'b0010, 0, 0);
    check_out("sat_setup_a", 0, 0, 4'b0010, 0);
    step(0, 1, 4'b0000, 0, 0);
    check_out("sat_setup_b", 1, 1, 4'b0000, 0);
    for (int f = 0; f <= 300; f++) begin
      step(0, 1, 4'b0001, 0, 0);
      check_out($sformatf("sat_fire%0d", f), 1, 1, 4'b0001, (f > 255) ? 8'd255 : 8'(f));
      step(0, 1, 4'b0000, 0, 0);
    end
    step(0, 1, 4'b0001, 0, 1);
    check_out("clr_with_drop", 1, 1, 4'b0001, 1);
    step(0, 1, 4'b0000, 0, 0);
    check_out("after_clr", 1, 1, 4'b0001, 1);

    // Mid-operation reset with ev_valid, pending=1010, ch0 held high
    step(0, 1, 4'b0000, 1, 0);
    check_out("rst_prep_a", 1, 0, 4'b0000, 1);
    step(0, 1, 4'b0000, 1, 0);
    check_out("rst_prep_b", 0, 0, 4'b0000, 1);
    step(0, 1, 4'b0010, 0, 0);
    check_out("rst_prep_c", 0, 0, 4'b0010, 1);
    step(0, 1, 4'b1000, 0, 0);
    check_out("rst_prep_d", 1, 1, 4'b1000, 1);
    step(0, 1, 4'b0010, 0, 0);
    check_out("rst_prep_e", 1, 1, 4'b1010, 1);
    step(1, 3, 4'b0001, 0, 0);
    check_out("rst_edge", 0, 0, 4'b0000, 0);
    step(0, 3, 4'b0001, 1, 0);
    check_out("post_rst_s1", 0, 0, 4'b0000, 0);
    step(0, 3, 4'b0001, 1, 0);
    check_out("post_rst_s2", 0, 0, 4'b0000, 0);
    step(0, 3, 4'b0001, 1, 0);
    check_out("post_rst_s3", 0, 0, 4'b0001, 0);
    step(0, 3, 4'b0001, 1, 0);
    check_out("post_rst_load", 1, 0, 4'b0000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
